bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Arbitrates the instruction cache and data cache onto the single RAM port, sitting directly downstream of the dcache/icache memory-side interface. It holds one granted requester per RAM transaction. It forwards that requester's address, data and enables to RAM, and returns wait/load to it. Data cache has priority, bounded by a starvation guard for the icache.

## Interface
- STARVE_LIMIT, 4, consecutive contested dcache grants after which a pending icache request wins the next arbitration
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dload  out  32  read data to dcache
- dwait  out  1  dcache stall; low for exactly the completing cycle
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iload  out  32  read data to icache
- iwait  out  1  icache stall; low for exactly the completing cycle
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

## Operation
- States: IDLE, DGNT, IGNT. Reset: state IDLE, starve_cnt 0.
- Requests:
  - dreq = dREN | dWEN.
  - ireq = iREN.
- Transitions out of IDLE:
  - dreq and not (ireq and starve_cnt == STARVE_LIMIT) -> DGNT. If ireq is also high, starve_cnt++ (saturating at STARVE_LIMIT).
  - else ireq -> IGNT, starve_cnt <= 0.
  - no request -> stay in IDLE, starve_cnt <= 0.
- DGNT:
  - ramstate == ACCESS -> IDLE.
  - dreq dropped -> IDLE, with no completion signalled. This covers a dcache halt or abort.
  - otherwise hold.
- IGNT: same rules as DGNT, using ireq.
- RAM drive, all combinational from state and the owner's live inputs:
  - DGNT: ramWEN = dWEN, ramREN = dREN & ~dWEN, ramaddr = daddr, ramstore = dstore. dWEN with dREN means write wins.
  - IGNT: ramREN = 1, ramaddr = iaddr, ramstore = 0.
  - IDLE: all RAM outputs 0.
- Return path:
  - dload = ramload and iload = ramload, at all times.
  - dwait = ~(state == DGNT & ramstate == ACCESS).
  - iwait = ~(state == IGNT & ramstate == ACCESS).
- ERROR or BUSY: owner is held and wait stays high. This gives implicit retry; no error flag.
- Reset values of outputs: ramREN = 0, ramWEN = 0, ramaddr = 0, ramstore = 0, dwait = 1, iwait = 1. dload and iload follow ramload.

## Timing
- Arbitration is registered. A request first seen in IDLE at cycle N drives RAM from cycle N+1.
- Completion: wait is low in the first granted cycle with ramstate == ACCESS.
  - For RAM with zero added latency, that is cycle N+1. The requester samples load at that edge.
- One IDLE bubble follows every completion.
  - Dcache two-word block fills (LD1, LD2) and writebacks therefore take at least 4 cycles.
  - The icache may win between the two words.
- Address or data changes by the owner while granted propagate to RAM immediately. The owner must hold them stable until its wait drops.
- Reset mid-transaction: state IDLE, RAM enables low, wait high on both sides in the same instant. There is no replay.
- Back-to-back dcache grants with iREN held: grants 1 to STARVE_LIMIT go to dcache; grant STARVE_LIMIT+1 goes to icache.

## Structure
- ramstate_t is in cpu_types_pkg.
- arb_state_t (IDLE, DGNT, IGNT) goes in diaosi_types_pkg.
- Single module with no sub-module. The FSM and starve counter sit in one always_ff; the next-state and output decode sit in always_comb.
- starve_cnt width is $clog2(STARVE_LIMIT+1).

## Test plan
- Reset: assert nRST=0 with dREN=1 and ramstate=ACCESS -> ramREN=0, dwait=1, iwait=1.
- Dcache read: daddr=0x40, dREN=1, RAM returns ACCESS one cycle after grant with ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x40 from the cycle after the request, dwait=0 for exactly 1 cycle, dload=0xDEADBEEF.
- Write priority: dREN=dWEN=1, daddr=0x80, dstore=0x1234 -> ramWEN=1, ramREN=0, ramstore=0x1234.
- Contention: dREN and iREN both raised together -> dcache served first, icache granted after the IDLE bubble. With dREN held continuously, the icache gets the 5th grant (STARVE_LIMIT=4).
- BUSY and ERROR: ramstate=BUSY for 3 cycles, then ERROR for 2, then ACCESS -> wait high for those 5 cycles, ramaddr stable, single completion.
- Abort: dcache drops dREN while in DGNT with ramstate=BUSY -> next cycle IDLE, no dwait pulse, and a pending iREN is granted the following cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
//   Types shared across the CPU memory system.
//   ramstate_t : status reported by the RAM port each cycle.
//     FREE   - RAM idle, no transaction in flight
//     BUSY   - transaction accepted, data not ready yet
//     ACCESS - transaction completes this cycle (load data valid)
//     ERROR  - transaction faulted; requester retries by holding its request
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage : cpu_types_pkg

// File: rtl/diaosi_types_pkg.sv
// ---------------------------------------------------------------------------
// diaosi_types_pkg
//   Types local to the cache/RAM interconnect.
//   arb_state_t : bus_arbiter ownership state.
//     IDLE - nobody owns the RAM port (arbitration happens here)
//     DGNT - data cache owns the RAM port
//     IGNT - instruction cache owns the RAM port
// ---------------------------------------------------------------------------
package diaosi_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DGNT = 2'd1,
        IGNT = 2'd2
    } arb_state_t;

endpackage : diaosi_types_pkg

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Shares the single RAM port between the data cache and the instruction
//   cache. One requester owns the port per transaction; the owner's address,
//   data and enables pass straight through to RAM and the RAM status is
//   turned into that owner's wait signal. Data cache wins arbitration unless
//   the icache has lost STARVE_LIMIT contested arbitrations in a row.
//
// Parameters
//   STARVE_LIMIT : contested dcache grants before a waiting icache wins
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   dREN, dWEN           dcache read / write request
//   daddr, dstore        dcache word address / write data
//   dload, dwait         read data / stall back to dcache
//   iREN, iaddr          icache read request / word address
//   iload, iwait         read data / stall back to icache
//   ramREN, ramWEN       RAM read / write enable
//   ramaddr, ramstore    RAM address / write data
//   ramload, ramstate    RAM read data / RAM status
// ---------------------------------------------------------------------------
module bus_arbiter
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,

    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,

    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,

    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q,      state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic dreq;
    logic ireq;
    logic icache_starved;
    logic ram_done;

    assign dreq           = dREN | dWEN;
    assign ireq           = iREN;
    assign icache_starved = ireq && (starve_cnt_q == CNT_MAX);
    assign ram_done       = (ramstate == ACCESS);

    // -----------------------------------------------------------------------
    // Next-state and starvation counter decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (dreq && !icache_starved) begin
                    state_d = DGNT;
                    // Only grants the icache actually competed for count
                    // towards starvation.
                    if (ireq && (starve_cnt_q != CNT_MAX)) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (ireq) begin
                    state_d      = IGNT;
                    starve_cnt_d = '0;
                end else begin
                    starve_cnt_d = '0;
                end
            end

            // Completion and abort both fall back to IDLE; abort simply never
            // produced a low wait. Completion always forces one IDLE bubble.
            DGNT: begin
                if (ram_done || !dreq) begin
                    state_d = IDLE;
                end
            end

            IGNT: begin
                if (ram_done || !ireq) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Ownership state and starvation counter
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // RAM drive and return path. Purely combinational from the registered
    // owner so that the owner's live address/data reach RAM without delay,
    // and so that an asynchronous reset drops the enables immediately.
    // -----------------------------------------------------------------------
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        dwait    = 1'b1;
        iwait    = 1'b1;

        unique case (state_q)
            DGNT: begin
                // A simultaneous read and write request is treated as a write.
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~ram_done;
            end

            IGNT: begin
                ramREN   = 1'b1;
                ramaddr  = iaddr;
                iwait    = ~ram_done;
            end

            default: begin
            end
        endcase
    end

    // Both caches see the RAM data bus; only the owner's deasserted wait
    // tells it the data is meaningful.
    assign dload = ramload;
    assign iload = ramload;

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        dREN, dWEN, iREN;
    logic [31:0] daddr, dstore, iaddr, ramload;
    logic [31:0] dload, iload, ramaddr, ramstore;
    logic        dwait, iwait, ramREN, ramWEN;
    ramstate_t   ramstate;

    int n_chk  = 0;
    int n_fail = 0;

    bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Port snapshot for an unowned RAM port
    task automatic chk_idle(input string tag);
        chk({tag, " ramREN"},  32'(ramREN),  32'd0);
        chk({tag, " ramWEN"},  32'(ramWEN),  32'd0);
        chk({tag, " ramaddr"}, ramaddr,      32'd0);
        chk({tag, " dwait"},   32'(dwait),   32'd1);
        chk({tag, " iwait"},   32'(iwait),   32'd1);
    endtask

    initial begin
        nRST = 1'b0; dREN = 1'b1; dWEN = 1'b0; iREN = 1'b0;
        daddr = 32'h0; dstore = 32'h0; iaddr = 32'h200;
        ramload = 32'h0; ramstate = ACCESS;

        // ---- reset held with a pending dcache request and ACCESS ----
        tick(); tick();
        chk_idle("reset");
        ramload = 32'hA5A5_0001;
        #1;
        chk("reset dload follows", dload, 32'hA5A5_0001);
        chk("reset iload follows", iload, 32'hA5A5_0001);

        // ---- reset mid-transaction: drops immediately, no clock needed ----
        daddr = 32'h44;
        nRST  = 1'b1;
        tick();
        chk("pre-reset ramREN",  32'(ramREN), 32'd1);
        chk("pre-reset ramaddr", ramaddr,     32'h44);
        chk("pre-reset dwait",   32'(dwait),  32'd0);
        #2 nRST = 1'b0;
        #1;
        chk_idle("async reset");
        dREN = 1'b0; ramstate = FREE;
        tick();
        nRST = 1'b1;
        tick();

        // ---- dcache read ----
        daddr = 32'h40; dREN = 1'b1;
        #1;
        chk("rd N ramREN", 32'(ramREN), 32'd0);
        tick();
        chk("rd grant ramREN",  32'(ramREN), 32'd1);
        chk("rd grant ramaddr", ramaddr,     32'h40);
        chk("rd grant dwait",   32'(dwait),  32'd1);
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        #1;
        chk("rd done dwait", 32'(dwait), 32'd0);
        chk("rd done dload", dload,      32'hDEADBEEF);
        tick();
        chk_idle("rd bubble");
        dREN = 1'b0; ramstate = FREE;
        tick();
        chk_idle("rd after");

        // ---- write wins over read ----
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
        tick();
        chk("wr ramWEN",   32'(ramWEN), 32'd1);
        chk("wr ramREN",   32'(ramREN), 32'd0);
        chk("wr ramstore", ramstore,    32'h1234);
        chk("wr ramaddr",  ramaddr,     32'h80);
        ramstate = ACCESS;
        #1;
        chk("wr dwait", 32'(dwait), 32'd0);
        tick();
        chk_idle("wr bubble");
        dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        tick();

        // ---- simultaneous requests: dcache first, icache after bubble ----
        daddr = 32'h100; iaddr = 32'h200; dREN = 1'b1; iREN = 1'b1;
        tick();
        chk("ct d ramaddr", ramaddr,     32'h100);
        chk("ct d iwait",   32'(iwait),  32'd1);
        ramstate = ACCESS;
        #1;
        chk("ct d dwait", 32'(dwait), 32'd0);
        chk("ct d iwait2", 32'(iwait), 32'd1);
        tick();
        chk_idle("ct bubble");
        dREN = 1'b0; ramstate = FREE;
        tick();
        chk("ct i ramREN",   32'(ramREN), 32'd1);
        chk("ct i ramWEN",   32'(ramWEN), 32'd0);
        chk("ct i ramaddr",  ramaddr,     32'h200);
        chk("ct i ramstore", ramstore,    32'd0);
        chk("ct i iwait",    32'(iwait),  32'd1);
        ramstate = ACCESS; ramload = 32'h0BAD_F00D;
        #1;
        chk("ct i iwait done", 32'(iwait), 32'd0);
        chk("ct i iload",      iload,      32'h0BAD_F00D);
        chk("ct i dwait",      32'(dwait), 32'd1);
        tick();
        chk_idle("ct i bubble");

        // ---- starvation guard: both held, 5th grant goes to icache ----
        dREN = 1'b1;
        for (int g = 1; g <= 5; g++) begin
            tick();
            if (g <= 4) begin
                chk($sformatf("starve g%0d ramaddr", g), ramaddr,     32'h100);
                chk($sformatf("starve g%0d dwait", g),   32'(dwait),  32'd0);
                chk($sformatf("starve g%0d iwait", g),   32'(iwait),  32'd1);
            end else begin
                chk($sformatf("starve g%0d ramaddr", g), ramaddr,     32'h200);
                chk($sformatf("starve g%0d dwait", g),   32'(dwait),  32'd1);
                chk($sformatf("starve g%0d iwait", g),   32'(iwait),  32'd0);
            end
            tick();
            chk_idle($sformatf("starve g%0d bubble", g));
        end
        dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
        tick();

        // ---- BUSY x3, ERROR x2, then ACCESS ----
        daddr = 32'h300; dREN = 1'b1; ramstate = BUSY;
        tick();
        for (int c = 0; c < 5; c++) begin
            if (c >= 3) ramstate = ERROR;
            #1;
            chk($sformatf("be c%0d dwait", c),   32'(dwait), 32'd1);
            chk($sformatf("be c%0d ramaddr", c), ramaddr,    32'h300);
            chk($sformatf("be c%0d ramREN", c),  32'(ramREN), 32'd1);
            tick();
        end
        ramstate = ACCESS;
        #1;
        chk("be done dwait", 32'(dwait), 32'd0);
        tick();
        chk_idle("be bubble");
        dREN = 1'b0; ramstate = FREE;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("be post c%0d dwait", c), 32'(dwait), 32'd1);
        end

        // ---- abort: dcache drops request while BUSY ----
        daddr = 32'h400; iaddr = 32'h500; dREN = 1'b1; iREN = 1'b1; ramstate = BUSY;
        tick();
        chk("ab grant ramaddr", ramaddr,    32'h400);
        chk("ab grant dwait",   32'(dwait), 32'd1);
        dREN = 1'b0;
        #1;
        chk("ab drop dwait", 32'(dwait), 32'd1);
        tick();
        chk_idle("ab idle");
        tick();
        chk("ab i ramREN",  32'(ramREN), 32'd1);
        chk("ab i ramaddr", ramaddr,     32'h500);
        chk("ab i iwait",   32'(iwait),  32'd1);
        chk("ab i dwait",   32'(dwait),  32'd1);
        ramstate = ACCESS;
        #1;
        chk("ab i iwait done", 32'(iwait), 32'd0);
        tick();
        chk_idle("ab i bubble");
        iREN = 1'b0; ramstate = FREE;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_bus_arbiter
